wrr_port_scheduler: RTL and testbench

//  Weighted round-robin scheduler for one switch output port. Arbitrates among the NUM_REQ input

---
 rtl/wrr_port_scheduler.sv | 156 +++++++++++++++
 tb/tb_wrr_port_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wrr_port_scheduler.sv
// Weighted round-robin grant scheduler for one switch output port.
// Holds a one-hot grant until done, abort (req drop) or hold watchdog expiry; credits enforce weights.
module wrr_port_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int WEIGHT_W   = 3,
   parameter int DEF_WEIGHT = 1,
   parameter int MAX_HOLD   = 16,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic                         done,
   input  logic                         cfg_load,
   input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         grant_valid,
   output logic [ID_W-1:0]              grant_id,
   output logic                         abort_p,
   output logic                         timeout_p
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]       grant_id_q, grant_id_d;
   logic                  abort_q, abort_d;
   logic                  timeout_q, timeout_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [WEIGHT_W-1:0]   weight_q [NUM_REQ];
   logic [WEIGHT_W-1:0]   weight_d [NUM_REQ];
   logic [WEIGHT_W-1:0]   credit_q [NUM_REQ];
   logic [WEIGHT_W-1:0]   credit_d [NUM_REQ];
   logic [WEIGHT_W-1:0]   cfg_w    [NUM_REQ];
   logic [NUM_REQ-1:0]    eligible;
   logic                  pick_found;
   logic [ID_W-1:0]       pick_idx;

   // A zero weight would starve its port forever, so it is stored as 1.
   function automatic logic [WEIGHT_W-1:0] clamp_weight(input logic [WEIGHT_W-1:0] w);
      return (w == '0) ? WEIGHT_W'(1) : w;
   endfunction

   function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         cfg_w[i]    = clamp_weight(weight_cfg[i*WEIGHT_W +: WEIGHT_W]);
         eligible[i] = req[i] && (credit_q[i] != '0);
      end
   end

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      abort_d    = 1'b0;
      timeout_d  = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      credit_d   = credit_q;
      weight_d   = weight_q;

      if (cfg_load) weight_d = cfg_w;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               grant_id_d        = pick_idx;
               hold_cnt_d        = '0;
               state_d           = GRANT;
            end else if (req != '0) begin
               // Everyone waiting is out of credit: refill, using weights loaded on this same edge.
               credit_d = cfg_load ? cfg_w : weight_q;
            end
         end
         GRANT: begin
            if (done) begin
               if (credit_q[grant_id_q] != '0) credit_d[grant_id_q] = credit_q[grant_id_q] - 1'b1;
               rr_ptr_d = (credit_q[grant_id_q] <= WEIGHT_W'(1) || !req[grant_id_q])
                          ? next_idx(grant_id_q) : grant_id_q;
               grant_d  = '0;
               state_d  = IDLE;
            end else if (!req[grant_id_q]) begin
               abort_d  = 1'b1;
               rr_ptr_d = next_idx(grant_id_q);
               grant_d  = '0;
               state_d  = IDLE;
            end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
               timeout_d            = 1'b1;
               credit_d[grant_id_q] = '0;
               rr_ptr_d             = next_idx(grant_id_q);
               grant_d              = '0;
               state_d              = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         abort_q    <= 1'b0;
         timeout_q  <= 1'b0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         // NOTE: weights and credits are architectural state, so these small arrays are reset, not left X.
         for (int i = 0; i < NUM_REQ; i++) begin
            weight_q[i] <= WEIGHT_W'(DEF_WEIGHT);
            credit_q[i] <= WEIGHT_W'(DEF_WEIGHT);
         end
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         abort_q    <= abort_d;
         timeout_q  <= timeout_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         weight_q   <= weight_d;
         credit_q   <= credit_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = grant_id_q;
   assign abort_p     = abort_q;
   assign timeout_p   = timeout_q;

endmodule

// File: tb/tb_wrr_port_scheduler.sv
// Directed self-checking bench for wrr_port_scheduler with hand-computed grant sequences.
module tb_wrr_port_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic        done;
   logic        cfg_load;
   logic [11:0] weight_cfg;
   logic [3:0]  grant;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic        abort_p;
   logic        timeout_p;

   int checks = 0;
   int errors = 0;

   wrr_port_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .cfg_load    (cfg_load),
      .weight_cfg  (weight_cfg),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .abort_p     (abort_p),
      .timeout_p   (timeout_p)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Step one clock edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      done     = 1'b0;
      cfg_load = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_weights(input logic [11:0] w);
      weight_cfg = w;
      cfg_load   = 1'b1;
      tick();
      cfg_load   = 1'b0;
   endtask

   task automatic check_grant(input string tag, input int exp_id);
      logic [3:0] oh;
      oh         = '0;
      oh[exp_id] = 1'b1;
      check({tag, "_grant"}, 32'(grant), 32'(oh));
      check({tag, "_id"}, 32'(grant_id), 32'(exp_id));
   endtask

   // Pulse done on the current grant, then expect one bubble (two with a refill) and the next grant.
   task automatic done_then_expect(input string tag, input int exp_id, input bit refill);
      done = 1'b1;
      tick();
      done = 1'b0;
      check({tag, "_bubble"}, 32'(grant_valid), 32'd0);
      if (refill) begin
         tick();
         check({tag, "_refill"}, 32'(grant_valid), 32'd0);
      end
      tick();
      check_grant(tag, exp_id);
   endtask

   initial begin
      weight_cfg = '0;
      do_reset();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_id", 32'(grant_id), 32'd0);
      check("rst_abort", 32'(abort_p), 32'd0);
      check("rst_timeout", 32'(timeout_p), 32'd0);

      // 1: equal weights, all requesting
      load_weights(12'h249);
      req = 4'b1111;
      tick();
      check_grant("s1_g0", 0);
      done_then_expect("s1_g1", 1, 1'b0);
      done_then_expect("s1_g2", 2, 1'b0);
      done_then_expect("s1_g3", 3, 1'b0);
      done_then_expect("s1_g4", 0, 1'b1);
      done_then_expect("s1_g5", 1, 1'b0);

      // 2: w0=3 w1=1; reset credits are 1 until the first refill
      do_reset();
      load_weights(12'h24B);
      req = 4'b0011;
      tick();
      check_grant("s2_g0", 0);
      done_then_expect("s2_g1", 1, 1'b0);
      done_then_expect("s2_g2", 0, 1'b1);
      done_then_expect("s2_g3", 0, 1'b0);
      done_then_expect("s2_g4", 0, 1'b0);
      done_then_expect("s2_g5", 1, 1'b0);
      done_then_expect("s2_g6", 0, 1'b1);

      // 3: single requester 2 with w2=2
      do_reset();
      load_weights(12'h289);
      req = 4'b0100;
      tick();
      check_grant("s3_g0", 2);
      done_then_expect("s3_g1", 2, 1'b1);
      done_then_expect("s3_g2", 2, 1'b0);
      done_then_expect("s3_g3", 2, 1'b1);

      // 4: hold watchdog
      do_reset();
      req = 4'b0001;
      tick();
      check_grant("s4_g0", 0);
      for (int i = 1; i < 16; i++) begin
         tick();
         check($sformatf("s4_hold%0d", i), 32'({grant_valid, timeout_p}), 32'b10);
      end
      tick();
      check("s4_to_valid", 32'(grant_valid), 32'd0);
      check("s4_to_pulse", 32'(timeout_p), 32'd1);
      tick();
      check("s4_refill_valid", 32'(grant_valid), 32'd0);
      check("s4_to_clear", 32'(timeout_p), 32'd0);
      tick();
      check_grant("s4_regrant", 0);

      // 5: abort on request drop
      do_reset();
      req = 4'b0110;
      tick();
      check_grant("s5_g0", 1);
      req = 4'b0100;
      tick();
      check("s5_abort", 32'(abort_p), 32'd1);
      check("s5_ab_valid", 32'(grant_valid), 32'd0);
      tick();
      check("s5_abort_clr", 32'(abort_p), 32'd0);
      check_grant("s5_g1", 2);
      req = 4'b0110;
      done_then_expect("s5_g2", 1, 1'b0);

      // 6: reset mid-grant, then all-zero weights behave as 1
      do_reset();
      req = 4'b0001;
      tick();
      check_grant("s6_g0", 0);
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      rst_n = 1'b1;
      check("s6_rst_grant", 32'(grant), 32'd0);
      check("s6_rst_abort", 32'(abort_p), 32'd0);
      check("s6_rst_timeout", 32'(timeout_p), 32'd0);
      load_weights(12'h000);
      req = 4'b0011;
      tick();
      check_grant("s6_g1", 0);
      done_then_expect("s6_g2", 1, 1'b0);
      done_then_expect("s6_g3", 0, 1'b1);
      done_then_expect("s6_g4", 1, 1'b0);

      // 7: cfg_load on the refill edge feeds the refill
      do_reset();
      req = 4'b0001;
      tick();
      check_grant("s7_g0", 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("s7_bubble", 32'(grant_valid), 32'd0);
      weight_cfg = 12'h24A;
      cfg_load   = 1'b1;
      tick();
      cfg_load   = 1'b0;
      check("s7_refill", 32'(grant_valid), 32'd0);
      tick();
      check_grant("s7_g1", 0);
      done_then_expect("s7_g2", 0, 1'b0);
      done_then_expect("s7_g3", 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
